cmos_size_cfg: RTL and testbench

//  Registered, frame-synchronous successor to the LCD-ID -> camera-size lookup. Maps panel ID plus scale mode to

---
 rtl/cmos_size_cfg.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cmos_size_cfg.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_size_cfg.sv
// -----------------------------------------------------------------------------
// cmos_size_cfg
//
// Frame-synchronous camera size configuration. The LCD panel ID and a scale
// mode select the CMOS active window (h x v), the sensor HTS/VTS totals and
// the SDRAM frame depth (h * v, computed by a serial shift-add multiplier).
// A freshly computed set is committed to the outputs all at once, and only
// on a frame boundary once a first set exists. The sensor configuration and
// the SDRAM controller therefore never see a mix of two sets.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   lcd_id            panel ID, sampled when lcd_id_vld = 1
//   lcd_id_vld        1-cycle pulse requesting a recompute for lcd_id
//   scale_mode        00 full, 01 half, 10 quarter, 11 full
//   frame_start       1-cycle pulse at the CMOS vsync edge
//   cmos_h_pixel      committed active width (scaled)
//   cmos_v_pixel      committed active height (scaled)
//   total_h_pixel     committed HTS (unscaled)
//   total_v_pixel     committed VTS (unscaled)
//   sdram_max_addr    committed h * v, saturated to all ones
//   cfg_valid         sticky flag: at least one set has been committed
//   cfg_update        1-cycle pulse in the commit cycle
//   id_known          committed set came from a table hit
//   busy              a computation or commit is in progress
// -----------------------------------------------------------------------------
module cmos_size_cfg #(
    parameter int PIX_W  = 13,
    parameter int ADDR_W = 24,
    parameter int DEF_H  = 800,
    parameter int DEF_V  = 480,
    parameter int DEF_HT = 1800,
    parameter int DEF_VT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       lcd_id,
    input  logic              lcd_id_vld,
    input  logic [1:0]        scale_mode,
    input  logic              frame_start,
    output logic [PIX_W-1:0]  cmos_h_pixel,
    output logic [PIX_W-1:0]  cmos_v_pixel,
    output logic [PIX_W-1:0]  total_h_pixel,
    output logic [PIX_W-1:0]  total_v_pixel,
    output logic [ADDR_W-1:0] sdram_max_addr,
    output logic              cfg_valid,
    output logic              cfg_update,
    output logic              id_known,
    output logic              busy
);

    localparam int ACC_W = 2 * PIX_W;
    localparam int CNT_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MUL,
        S_WAIT_FRAME,
        S_COMMIT
    } state_t;

    state_t state_q, state_d;

    // Request capture
    logic [1:0]  mode_q;
    logic [15:0] id_s_q;
    logic [1:0]  mode_s_q;
    logic        req;

    // Staging set (built in LOOKUP, copied to outputs on commit)
    logic [PIX_W-1:0] h_s_q, v_s_q, ht_s_q, vt_s_q;
    logic             known_s_q;

    // Serial multiplier
    logic [PIX_W-1:0] mplier_q;
    logic [ACC_W-1:0] mcand_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mul_last;

    // Committed outputs
    logic [PIX_W-1:0]  cmos_h_q, cmos_v_q, total_h_q, total_v_q;
    logic [ADDR_W-1:0] max_addr_q;
    logic              cfg_valid_q, id_known_q;

    // Table lookup and scaling
    logic [PIX_W-1:0] lk_h, lk_v, lk_ht, lk_vt;
    logic [PIX_W-1:0] sc_h, sc_v;
    logic             lk_known;
    logic [ADDR_W-1:0] addr_sat;

    // A mode change only counts as a request once a set exists; before that
    // the pending first computation simply picks up the mode captured with
    // the ID.
    assign req      = lcd_id_vld | (cfg_valid_q & (scale_mode != mode_q));
    assign mul_last = (cnt_q == CNT_W'(PIX_W - 1));

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lk_h     = PIX_W'(DEF_H);
        lk_v     = PIX_W'(DEF_V);
        lk_ht    = PIX_W'(DEF_HT);
        lk_vt    = PIX_W'(DEF_VT);
        lk_known = 1'b0;
        case (id_s_q)
            16'h4342: begin
                lk_h = PIX_W'(480);  lk_v = PIX_W'(272);
                lk_ht = PIX_W'(1800); lk_vt = PIX_W'(1000); lk_known = 1'b1;
            end
            16'h7084: begin
                lk_h = PIX_W'(800);  lk_v = PIX_W'(480);
                lk_ht = PIX_W'(1800); lk_vt = PIX_W'(1000); lk_known = 1'b1;
            end
            16'h7016: begin
                lk_h = PIX_W'(1024); lk_v = PIX_W'(600);
                lk_ht = PIX_W'(2200); lk_vt = PIX_W'(1000); lk_known = 1'b1;
            end
            16'h1018: begin
                lk_h = PIX_W'(1280); lk_v = PIX_W'(800);
                lk_ht = PIX_W'(2570); lk_vt = PIX_W'(980);  lk_known = 1'b1;
            end
            default: ;
        endcase
    end

    // Scaling truncates; totals stay unscaled because the sensor timing
    // does not change with the output window.
    always_comb begin
        sc_h = lk_h;
        sc_v = lk_v;
        case (mode_s_q)
            2'b01: begin
                sc_h = lk_h >> 1;
                sc_v = lk_v >> 1;
            end
            2'b10: begin
                sc_h = lk_h >> 2;
                sc_v = lk_v >> 2;
            end
            default: ;
        endcase
    end

    // One multiplier bit per MUL cycle, LSB first.
    always_comb begin
        acc_d = acc_q;
        if (state_q == S_MUL && mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    generate
        if (ACC_W > ADDR_W) begin : g_sat
            always_comb begin
                addr_sat = (|acc_d[ACC_W-1:ADDR_W]) ? '1 : acc_d[ADDR_W-1:0];
            end
        end else begin : g_nosat
            always_comb begin
                addr_sat = ADDR_W'(acc_d);
            end
        end
    endgenerate

    // Any request restarts the computation from LOOKUP, whatever the state,
    // so a stale set can never reach COMMIT. A request coinciding with
    // frame_start in WAIT_FRAME therefore wins over the commit.
    always_comb begin
        state_d = state_q;
        if (req) begin
            state_d = S_LOOKUP;
        end else begin
            case (state_q)
                S_IDLE:       state_d = S_IDLE;
                S_LOOKUP:     state_d = S_MUL;
                S_MUL:        if (mul_last) state_d = cfg_valid_q ? S_WAIT_FRAME : S_COMMIT;
                S_WAIT_FRAME: if (frame_start) state_d = S_COMMIT;
                S_COMMIT:     state_d = S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'b00;
            id_s_q     <= '0;
            mode_s_q   <= 2'b00;
            h_s_q      <= '0;
            v_s_q      <= '0;
            ht_s_q     <= '0;
            vt_s_q     <= '0;
            known_s_q  <= 1'b0;
            mplier_q   <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            cmos_h_q   <= '0;
            cmos_v_q   <= '0;
            total_h_q  <= '0;
            total_v_q  <= '0;
            max_addr_q <= '0;
            cfg_valid_q <= 1'b0;
            id_known_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= scale_mode;

            // A mode-only request keeps the last captured ID.
            if (req) begin
                if (lcd_id_vld) id_s_q <= lcd_id;
                mode_s_q <= scale_mode;
            end

            if (state_q == S_LOOKUP) begin
                h_s_q     <= sc_h;
                v_s_q     <= sc_v;
                ht_s_q    <= lk_ht;
                vt_s_q    <= lk_vt;
                known_s_q <= lk_known;
                mplier_q  <= sc_h;
                mcand_q   <= ACC_W'(sc_v);
                acc_q     <= '0;
                cnt_q     <= '0;
            end

            if (state_q == S_MUL) begin
                acc_q    <= acc_d;
                mplier_q <= mplier_q >> 1;
                mcand_q  <= mcand_q << 1;
                cnt_q    <= cnt_q + 1'b1;
            end

            // Outputs load on the edge entering COMMIT, so the whole set and
            // cfg_update become visible in the same cycle. acc_d already
            // holds the final partial product when MUL goes straight here.
            if (state_d == S_COMMIT) begin
                cmos_h_q    <= h_s_q;
                cmos_v_q    <= v_s_q;
                total_h_q   <= ht_s_q;
                total_v_q   <= vt_s_q;
                max_addr_q  <= addr_sat;
                id_known_q  <= known_s_q;
                cfg_valid_q <= 1'b1;
            end
        end
    end

    assign cmos_h_pixel   = cmos_h_q;
    assign cmos_v_pixel   = cmos_v_q;
    assign total_h_pixel  = total_h_q;
    assign total_v_pixel  = total_v_q;
    assign sdram_max_addr = max_addr_q;
    assign cfg_valid      = cfg_valid_q;
    assign id_known       = id_known_q;
    assign cfg_update     = (state_q == S_COMMIT);
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmos_size_cfg.sv
// -----------------------------------------------------------------------------
// tb_cmos_size_cfg
//
// Self-checking bench for cmos_size_cfg. Two instances share stimulus: the
// default one, and one whose default size is 8191x8191 so that unknown IDs
// drive the h*v product past the SDRAM address range.
// -----------------------------------------------------------------------------
module tb_cmos_size_cfg;

    localparam int PIX_W  = 13;
    localparam int ADDR_W = 24;
    localparam int SAT_D  = 8191;

    typedef struct packed {
        logic [PIX_W-1:0]  h;
        logic [PIX_W-1:0]  v;
        logic [PIX_W-1:0]  ht;
        logic [PIX_W-1:0]  vt;
        logic [ADDR_W-1:0] addr;
        logic              known;
    } exp_t;

    typedef struct {
        logic [15:0] id;
        logic [1:0]  mode;
        logic        vld;
        int          hold;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] lcd_id;
    logic        lcd_id_vld;
    logic [1:0]  scale_mode;
    logic        frame_start;

    logic [PIX_W-1:0]  h_m, v_m, ht_m, vt_m, h_s, v_s, ht_s, vt_s;
    logic [ADDR_W-1:0] addr_m, addr_s;
    logic valid_m, upd_m, known_m, busy_m;
    logic valid_s, upd_s, known_s, busy_s;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t prev_m, prev_s;
    logic [15:0] cur_id;

    cmos_size_cfg u_dut (
        .clk(clk), .rst_n(rst_n), .lcd_id(lcd_id), .lcd_id_vld(lcd_id_vld),
        .scale_mode(scale_mode), .frame_start(frame_start),
        .cmos_h_pixel(h_m), .cmos_v_pixel(v_m), .total_h_pixel(ht_m),
        .total_v_pixel(vt_m), .sdram_max_addr(addr_m), .cfg_valid(valid_m),
        .cfg_update(upd_m), .id_known(known_m), .busy(busy_m)
    );

    cmos_size_cfg #(.DEF_H(SAT_D), .DEF_V(SAT_D)) u_sat (
        .clk(clk), .rst_n(rst_n), .lcd_id(lcd_id), .lcd_id_vld(lcd_id_vld),
        .scale_mode(scale_mode), .frame_start(frame_start),
        .cmos_h_pixel(h_s), .cmos_v_pixel(v_s), .total_h_pixel(ht_s),
        .total_v_pixel(vt_s), .sdram_max_addr(addr_s), .cfg_valid(valid_s),
        .cfg_update(upd_s), .id_known(known_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(int h, int v, int ht, int vt, longint addr, bit known);
        exp_t r;
        r.h = PIX_W'(h);
        r.v = PIX_W'(v);
        r.ht = PIX_W'(ht);
        r.vt = PIX_W'(vt);
        r.addr = ADDR_W'(addr);
        r.known = known;
        return r;
    endfunction

    // Reference: table lookup, integer division for scaling, saturating product.
    function automatic exp_t model(logic [15:0] id, logic [1:0] mode, int dh, int dv);
        int h, v, ht, vt, div;
        bit kn;
        longint p;
        kn = 1'b1;
        case (id)
            16'h4342: begin h = 480;  v = 272; ht = 1800; vt = 1000; end
            16'h7084: begin h = 800;  v = 480; ht = 1800; vt = 1000; end
            16'h7016: begin h = 1024; v = 600; ht = 2200; vt = 1000; end
            16'h1018: begin h = 1280; v = 800; ht = 2570; vt = 980;  end
            default:  begin h = dh;   v = dv;  ht = 1800; vt = 1000; kn = 1'b0; end
        endcase
        div = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
        h = h / div;
        v = v / div;
        p = longint'(h) * longint'(v);
        if (p > (longint'(1) << ADDR_W) - 1) p = (longint'(1) << ADDR_W) - 1;
        return mk(h, v, ht, vt, p, kn);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    task automatic check_set(input string tag, input exp_t e, input exp_t es);
        check({tag, "_h"}, h_m, e.h);
        check({tag, "_v"}, v_m, e.v);
        check({tag, "_ht"}, ht_m, e.ht);
        check({tag, "_vt"}, vt_m, e.vt);
        check({tag, "_addr"}, addr_m, e.addr);
        check({tag, "_known"}, known_m, e.known);
        check({tag, "_sat_h"}, h_s, es.h);
        check({tag, "_sat_v"}, v_s, es.v);
        check({tag, "_sat_addr"}, addr_s, es.addr);
        check({tag, "_sat_known"}, known_s, es.known);
    endtask

    // One request with cfg_valid = 1: the set must wait for frame_start.
    task automatic run_txn(input string tag, input logic [15:0] id, input logic [1:0] mode,
                           input logic vld, input int hold, input exp_t e);
        int   pulses;
        exp_t es;
        pulses = 0;
        if (vld) cur_id = id;
        es = model(cur_id, mode, SAT_D, SAT_D);
        lcd_id = id;
        scale_mode = mode;
        lcd_id_vld = vld;
        tick();
        lcd_id_vld = 1'b0;
        check({tag, "_busy"}, busy_m, 1'b1);
        repeat (hold) begin
            tick();
            if (upd_m) pulses++;
        end
        check({tag, "_no_early_update"}, pulses, 0);
        check({tag, "_hold_h"}, h_m, prev_m.h);
        check({tag, "_hold_addr"}, addr_m, prev_m.addr);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check({tag, "_update"}, upd_m, 1'b1);
        check_set(tag, e, es);
        prev_m = e;
        prev_s = es;
    endtask

    vec_t vecs[9];

    initial begin
        int   n;
        int   pulses;
        exp_t e;

        vecs[0] = '{id: 16'h1018, mode: 2'd0, vld: 1'b1, hold: 50, e: mk(1280, 800, 2570, 980, 1024000, 1)};
        vecs[1] = '{id: 16'h7016, mode: 2'd0, vld: 1'b1, hold: 14, e: mk(1024, 600, 2200, 1000, 614400, 1)};
        vecs[2] = '{id: 16'h0000, mode: 2'd1, vld: 1'b0, hold: 20, e: mk(512, 300, 2200, 1000, 153600, 1)};
        vecs[3] = '{id: 16'h4342, mode: 2'd3, vld: 1'b1, hold: 16, e: mk(480, 272, 1800, 1000, 130560, 1)};
        vecs[4] = '{id: 16'hABCD, mode: 2'd0, vld: 1'b1, hold: 16, e: mk(800, 480, 1800, 1000, 384000, 0)};
        vecs[5] = '{id: 16'h1018, mode: 2'd2, vld: 1'b1, hold: 18, e: mk(320, 200, 2570, 980, 64000, 1)};
        vecs[6] = '{id: 16'h4342, mode: 2'd2, vld: 1'b1, hold: 16, e: mk(120, 68, 1800, 1000, 8160, 1)};
        vecs[7] = '{id: 16'h0000, mode: 2'd1, vld: 1'b1, hold: 16, e: mk(400, 240, 1800, 1000, 96000, 0)};
        vecs[8] = '{id: 16'hFFFF, mode: 2'd2, vld: 1'b0, hold: 16, e: mk(200, 120, 1800, 1000, 24000, 0)};

        rst_n = 1'b0;
        lcd_id = '0;
        lcd_id_vld = 1'b0;
        scale_mode = 2'b00;
        frame_start = 1'b0;
        cur_id = '0;
        repeat (2) tick();

        // Reset state
        check_set("reset", '0, '0);
        check("reset_valid", valid_m, 1'b0);
        check("reset_busy", busy_m, 1'b0);
        check("reset_update", upd_m, 1'b0);

        // First set commits without frame_start, PIX_W+2 cycles after the request.
        rst_n = 1'b1;
        lcd_id = 16'h7084;
        lcd_id_vld = 1'b1;
        cur_id = 16'h7084;
        tick();
        lcd_id_vld = 1'b0;
        n = 1;
        while (!upd_m && n < 100) begin
            tick();
            n++;
        end
        check("first_latency", n, PIX_W + 2);
        e = mk(800, 480, 1800, 1000, 384000, 1);
        check_set("first", e, e);
        check("first_valid", valid_m, 1'b1);
        prev_m = e;
        prev_s = e;
        tick();
        check("first_pulse_len", upd_m, 1'b0);
        check("first_valid_sticky", valid_m, 1'b1);
        check("first_idle", busy_m, 1'b0);

        // Table-driven commits (requests alternate between COMMIT-cycle and idle)
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 1) tick();
            run_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].mode, vecs[i].vld, vecs[i].hold, vecs[i].e);
        end

        // Abort mid-MUL: only the second ID is ever committed.
        tick();
        lcd_id = 16'hABCD;
        scale_mode = 2'b00;
        lcd_id_vld = 1'b1;
        tick();
        lcd_id_vld = 1'b0;
        repeat (5) tick();
        cur_id = 16'h4342;
        run_txn("abort", 16'h4342, 2'b00, 1'b1, 16, mk(480, 272, 1800, 1000, 130560, 1));
        pulses = 0;
        repeat (30) begin
            tick();
            if (upd_m) pulses++;
        end
        check("abort_single_update", pulses, 0);

        // Request coincident with frame_start in WAIT_FRAME; frame_start in MUL ignored.
        lcd_id = 16'h7084;
        lcd_id_vld = 1'b1;
        tick();
        lcd_id_vld = 1'b0;
        pulses = 0;
        repeat (16) begin
            tick();
            if (upd_m) pulses++;
        end
        lcd_id = 16'h1018;
        lcd_id_vld = 1'b1;
        frame_start = 1'b1;
        tick();
        lcd_id_vld = 1'b0;
        frame_start = 1'b0;
        if (upd_m) pulses++;
        repeat (5) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        if (upd_m) pulses++;
        repeat (12) begin
            tick();
            if (upd_m) pulses++;
        end
        check("collide_no_update", pulses, 0);
        check("collide_hold_h", h_m, prev_m.h);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("collide_update", upd_m, 1'b1);
        cur_id = 16'h1018;
        e = mk(1280, 800, 2570, 980, 1024000, 1);
        check_set("collide", e, e);
        prev_m = e;
        prev_s = e;

        // Randomized requests against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [15:0] rid;
            logic [1:0]  rmode;
            logic        rvld;
            int          sel;
            repeat ($urandom_range(0, 3)) tick();
            sel = $urandom_range(0, 5);
            case (sel)
                0: rid = 16'h4342;
                1: rid = 16'h7084;
                2: rid = 16'h7016;
                3: rid = 16'h1018;
                default: rid = 16'($urandom);
            endcase
            rvld = ($urandom_range(0, 3) != 0);
            if (rvld) rmode = 2'($urandom_range(0, 3));
            else rmode = scale_mode + 2'($urandom_range(1, 3));
            run_txn($sformatf("rand%0d", i), rid, rmode, rvld, 14 + $urandom_range(0, 10),
                    model(rvld ? rid : cur_id, rmode, 800, 480));
        end

        // Reset mid-MUL
        tick();
        lcd_id = 16'h7084;
        lcd_id_vld = 1'b1;
        tick();
        lcd_id_vld = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check_set("midreset", '0, '0);
        check("midreset_valid", valid_m, 1'b0);
        check("midreset_busy", busy_m, 1'b0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            tick();
            if (upd_m) pulses++;
        end
        check("midreset_no_commit", pulses, 0);
        check("midreset_stays_invalid", valid_m, 1'b0);

        // Abort before the first commit: stale set must not commit immediately.
        scale_mode = 2'b00;
        lcd_id = 16'hABCD;
        lcd_id_vld = 1'b1;
        tick();
        lcd_id_vld = 1'b0;
        repeat (4) tick();
        lcd_id = 16'h4342;
        lcd_id_vld = 1'b1;
        tick();
        lcd_id_vld = 1'b0;
        n = 1;
        pulses = 0;
        while (!upd_m && n < 100) begin
            tick();
            n++;
        end
        check("fresh_abort_latency", n, PIX_W + 2);
        e = mk(480, 272, 1800, 1000, 130560, 1);
        check_set("fresh_abort", e, e);
        repeat (40) begin
            tick();
            if (upd_m) pulses++;
        end
        check("fresh_abort_single", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
